// File: rtl/rv32_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 size codes,
// FSM state encodings and the access-size decode used by datapath and FSM.
package rv32_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    // Unused funct3 codes (011/110/111) fall through to a word access.
    function automatic lsu_size_t size_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/rv32_lsu_if.sv
// Handshaked data-bus bundle between the load/store unit (master) and memory (slave).
interface rv32_lsu_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, rdata, err
    );

endinterface

// File: rtl/rv32_lsu_align.sv
// Combinational lane logic: store byte-enable/data steering and load
// byte/half extraction with sign or zero extension.
module lsu_align
    import rv32_lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (size_of(st_funct3))
            SZ_BYTE: begin
                st_be    = 4'b0001 << st_addr_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    // funct3[2] distinguishes the unsigned (zero-extending) load variants.
    always_comb begin
        ld_byte = ld_word[{ld_addr_lo, 3'b000} +: 8];
        ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        ld_data = ld_word;
        case (size_of(ld_funct3))
            SZ_BYTE: ld_data = ld_funct3[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = ld_funct3[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/rv32_lsu.sv
// Multi-cycle load/store unit: stalls the core while one bus transfer is outstanding.
// Optional LSU_MISALIGN_TRAP_EN faults misaligned half/word accesses without touching the bus.
module rv32_lsu
    import rv32_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        fault,
    rv32_lsu_if.master  bus
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [1:0]    state;
    logic [2:0]    funct3_r;
    logic [1:0]    addr_lo_r;
    logic          fault_r;
    logic [31:0]   rdata_r;
    logic [CW-1:0] cnt;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;
    logic [31:0]   ld_data;
    logic          misalign;
    logic          timeout_hit;

    lsu_align u_align (
        .st_funct3  (req_funct3),
        .st_addr_lo (req_addr[1:0]),
        .st_data    (req_wdata),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .ld_funct3  (funct3_r),
        .ld_addr_lo (addr_lo_r),
        .ld_word    (bus.rdata),
        .ld_data    (ld_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((size_of(req_funct3) == SZ_HALF) && req_addr[0]) ||
                      ((size_of(req_funct3) == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            funct3_r  <= '0;
            addr_lo_r <= '0;
            fault_r   <= 1'b0;
            rdata_r   <= '0;
            cnt       <= '0;
            bus.req   <= 1'b0;
            bus.we    <= 1'b0;
            bus.addr  <= '0;
            bus.wdata <= '0;
            bus.be    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        funct3_r  <= req_funct3;
                        addr_lo_r <= req_addr[1:0];
                        bus.we    <= req_we;
                        bus.addr  <= {req_addr[31:2], 2'b00};
                        bus.wdata <= st_wdata;
                        bus.be    <= st_be;
                        cnt       <= '0;
                        // A trapped access completes next cycle without ever raising bus_req.
                        if (misalign) begin
                            fault_r <= 1'b1;
                            rdata_r <= '0;
                            state   <= ST_DONE;
                        end else begin
                            fault_r <= 1'b0;
                            bus.req <= 1'b1;
                            state   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.req && bus.ack) begin
                        bus.req <= 1'b0;
                        fault_r <= bus.err;
                        if (!bus.we) begin
                            rdata_r <= ld_data;
                        end
                        state   <= ST_DONE;
                    end else if (timeout_hit) begin
                        bus.req <= 1'b0;
                        fault_r <= 1'b1;
                        rdata_r <= '0;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Gated by rst so a core still holding req_valid sees no stall during reset.
    assign stall       = rst & (((state == ST_IDLE) & req_valid) | (state == ST_REQ));
    assign rdata       = rdata_r;
    assign rdata_valid = (state == ST_DONE) & ~bus.we & ~fault_r;
    assign fault       = (state == ST_DONE) & fault_r;

endmodule
